// File: rtl/mem_arbiter_pkg.sv
// Shared types for the icache/dcache RAM arbiter: RAM handshake state,
// word type and the arbiter's grant state.
package mem_arbiter_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2
  } arbstate_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of cache-side and RAM-side signals around the arbiter.
// slave = arbiter view, master = caches + RAM view.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      ram_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: one word transaction at a time, dcache preferred,
// icache forced in after IMAX_WAIT dcache completions while it is waiting.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int IMAX_WAIT = 4,
  parameter int WORD_W    = 32
) (
  input logic           CLK,
  input logic           RST,
  mem_arbiter_if.slave  bus
);

  arbstate_t  state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       err_q, err_d;

  logic  d_req_s, access_s, starved_s;
  logic  ram_ren_s, ram_wen_s, iwait_s, dwait_s;
  word_t ram_addr_s, ram_store_s, iload_s, dload_s;

  assign d_req_s   = bus.dREN | bus.dWEN;
  assign access_s  = (bus.ramstate == ACCESS);
  assign starved_s = (starve_q == IMAX_WAIT[3:0]);

  // Next-state, starvation counter and combinational RAM/cache outputs.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    err_d       = err_q | (bus.ramstate == ERROR);
    ram_ren_s   = 1'b0;
    ram_wen_s   = 1'b0;
    ram_addr_s  = {WORD_W{1'b0}};
    ram_store_s = {WORD_W{1'b0}};
    iwait_s     = 1'b1;
    dwait_s     = 1'b1;
    iload_s     = {WORD_W{1'b0}};
    dload_s     = {WORD_W{1'b0}};
    case (state_q)
      IDLE: begin
        if (!bus.iREN) begin
          starve_d = 4'd0;
        end else begin
          starve_d = starve_q;
        end
        if (bus.iREN && (starved_s || !d_req_s)) begin
          state_d = GNT_I;
        end else if (d_req_s) begin
          state_d = GNT_D;
        end else begin
          state_d = IDLE;
        end
      end
      GNT_D: begin
        ram_wen_s   = bus.dWEN;
        ram_ren_s   = bus.dREN & ~bus.dWEN;
        ram_addr_s  = bus.daddr;
        ram_store_s = bus.dstore;
        if (!d_req_s) begin
          state_d = IDLE;
        end else if (access_s) begin
          dwait_s = 1'b0;
          dload_s = bus.ramload;
          state_d = IDLE;
          if (bus.iREN && !starved_s) begin
            starve_d = starve_q + 4'd1;
          end else begin
            starve_d = starve_q;
          end
        end else begin
          state_d = GNT_D;
        end
      end
      GNT_I: begin
        ram_ren_s  = 1'b1;
        ram_addr_s = bus.iaddr;
        if (!bus.iREN) begin
          state_d = IDLE;
        end else if (access_s) begin
          iwait_s  = 1'b0;
          iload_s  = bus.ramload;
          starve_d = 4'd0;
          state_d  = IDLE;
        end else begin
          state_d = GNT_I;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Reset silences the RAM port and suppresses any completion pulse at once.
    if (RST) begin
      ram_ren_s   = 1'b0;
      ram_wen_s   = 1'b0;
      ram_addr_s  = {WORD_W{1'b0}};
      ram_store_s = {WORD_W{1'b0}};
      iwait_s     = 1'b1;
      dwait_s     = 1'b1;
      iload_s     = {WORD_W{1'b0}};
      dload_s     = {WORD_W{1'b0}};
    end else begin
      ram_ren_s = ram_ren_s;
    end
  end

  // State, starvation counter and sticky error flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      starve_q <= 4'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  assign bus.ramREN   = ram_ren_s;
  assign bus.ramWEN   = ram_wen_s;
  assign bus.ramaddr  = ram_addr_s;
  assign bus.ramstore = ram_store_s;
  assign bus.iwait    = iwait_s;
  assign bus.dwait    = dwait_s;
  assign bus.iload    = iload_s;
  assign bus.dload    = dload_s;
  assign bus.ram_err  = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// compared every cycle against a transaction-level owner/starvation model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int IMAX = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  mem_arbiter_if bus();

  mem_arbiter #(.IMAX_WAIT(IMAX), .WORD_W(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model: who owns the RAM (0 nobody, 1 dcache, 2 icache)
  int m_owner  = 0;
  int m_starve = 0;
  bit m_err    = 1'b0;

  // RAM behaviour knobs
  bit rnd_ram = 1'b0;
  int lat     = 0;
  int err_n   = 0;
  int ram_cnt = 0;
  bit strobe_seen;

  int    comp_q[$];
  word_t last_dload, last_iload;
  bit    seen_wr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit dreq, acc;
    logic e_ren, e_wen, e_iw, e_dw;
    word_t e_addr, e_store, e_il, e_dl;
    dreq = bus.dREN | bus.dWEN;
    acc  = (bus.ramstate == ACCESS);
    e_ren = 1'b0; e_wen = 1'b0; e_iw = 1'b1; e_dw = 1'b1;
    e_addr = 32'd0; e_store = 32'd0; e_il = 32'd0; e_dl = 32'd0;
    if (!RST && m_owner == 1) begin
      e_wen   = bus.dWEN;
      e_ren   = bus.dREN && !bus.dWEN;
      e_addr  = bus.daddr;
      e_store = bus.dstore;
      if (dreq && acc) begin
        e_dw = 1'b0;
        e_dl = bus.ramload;
      end
    end else if (!RST && m_owner == 2) begin
      e_ren  = 1'b1;
      e_addr = bus.iaddr;
      if (bus.iREN && acc) begin
        e_iw = 1'b0;
        e_il = bus.ramload;
      end
    end
    chk("ramREN", bus.ramREN, e_ren);
    chk("ramWEN", bus.ramWEN, e_wen);
    chk("ramaddr", bus.ramaddr, e_addr);
    chk("ramstore", bus.ramstore, e_store);
    chk("iwait", bus.iwait, e_iw);
    chk("dwait", bus.dwait, e_dw);
    chk("iload", bus.iload, e_il);
    chk("dload", bus.dload, e_dl);
    chk("ram_err", bus.ram_err, m_err);
  endtask

  task automatic model_step();
    bit dreq, acc;
    dreq = bus.dREN | bus.dWEN;
    acc  = (bus.ramstate == ACCESS);
    if (RST) begin
      m_owner = 0; m_starve = 0; m_err = 1'b0;
    end else begin
      if (bus.ramstate == ERROR) m_err = 1'b1;
      case (m_owner)
        0: begin
          if (bus.iREN && (m_starve == IMAX || !dreq)) m_owner = 2;
          else if (dreq) m_owner = 1;
          if (!bus.iREN) m_starve = 0;
        end
        1: begin
          if (!dreq) m_owner = 0;
          else if (acc) begin
            m_owner = 0;
            if (bus.iREN && m_starve < IMAX) m_starve++;
          end
        end
        2: begin
          if (!bus.iREN) m_owner = 0;
          else if (acc) begin
            m_owner = 0;
            m_starve = 0;
          end
        end
        default: m_owner = 0;
      endcase
    end
  endtask

  // one clock: drive RAM response, check outputs, advance model across the edge
  task automatic tick();
    int r;
    #1;
    if (rnd_ram) begin
      r = $urandom_range(0, 9);
      bus.ramstate = (r < 4) ? ACCESS : (r < 7) ? BUSY : (r < 9) ? FREE : ERROR;
      bus.ramload  = $urandom;
    end else if (bus.ramREN || bus.ramWEN) begin
      bus.ramstate = (ram_cnt < err_n) ? ERROR : (ram_cnt < err_n + lat) ? BUSY : ACCESS;
    end else begin
      bus.ramstate = FREE;
    end
    #1;
    check_outputs();
    strobe_seen = bus.ramREN | bus.ramWEN;
    if (bus.ramWEN && bus.ramaddr == 32'h80 && bus.ramstore == 32'h12345678) seen_wr = 1'b1;
    if (!RST && bus.dwait === 1'b0) begin comp_q.push_back(1); last_dload = bus.dload; end
    if (!RST && bus.iwait === 1'b0) begin comp_q.push_back(2); last_iload = bus.iload; end
    @(posedge CLK);
    model_step();
    if (strobe_seen && bus.ramstate != ACCESS) ram_cnt++;
    else ram_cnt = 0;
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic run_until(input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (comp_q.size() >= n) break;
      tick();
    end
  endtask

  initial begin
    int exp_seq[10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    bus.iREN = 1'b1; bus.iaddr = 32'd0; bus.dREN = 1'b1; bus.dWEN = 1'b0;
    bus.daddr = 32'd0; bus.dstore = 32'd0; bus.ramload = 32'd0; bus.ramstate = FREE;
    seen_wr = 1'b0;

    // reset with both caches requesting
    @(posedge CLK);
    model_step();
    #1;
    tick();
    tick();
    chk("rst_ram_err", bus.ram_err, 1'b0);
    RST = 1'b0;

    // both request: dcache first, then icache
    bus.iaddr = 32'h100; bus.daddr = 32'h40; lat = 2; bus.ramload = 32'hDEADBEEF;
    comp_q.delete();
    for (int k = 0; k < 30 && comp_q.size() < 2; k++) begin
      tick();
      if (comp_q.size() == 1 && bus.dREN) begin
        bus.dREN = 1'b0;
        bus.ramload = 32'hCAFEF00D;
      end
    end
    chk("both_n", comp_q.size(), 2);
    if (comp_q.size() == 2) begin
      chk("both_first_d", comp_q[0], 1);
      chk("both_then_i", comp_q[1], 2);
    end
    chk("both_dload", last_dload, 32'hDEADBEEF);
    chk("both_iload", last_iload, 32'hCAFEF00D);
    bus.iREN = 1'b0;
    tick();

    // starvation: both held, icache forced in after IMAX dcache completions
    do_reset();
    bus.iREN = 1'b1; bus.dREN = 1'b1; lat = 0;
    comp_q.delete();
    run_until(10, 80);
    chk("starve_n", comp_q.size(), 10);
    for (int k = 0; k < 10 && k < comp_q.size(); k++) chk("starve_seq", comp_q[k], exp_seq[k]);
    bus.iREN = 1'b0; bus.dREN = 1'b0;
    tick();

    // write wins over read when both strobes set
    do_reset();
    bus.dWEN = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'h12345678; lat = 1;
    comp_q.delete();
    run_until(1, 20);
    chk("wr_done", comp_q.size(), 1);
    chk("wr_seen", seen_wr, 1'b1);
    bus.dWEN = 1'b0; bus.dREN = 1'b0;
    tick();

    // ERROR cycles: held strobes, sticky flag until reset
    bus.dREN = 1'b1; bus.daddr = 32'h44; err_n = 3; lat = 0;
    comp_q.delete();
    run_until(1, 20);
    chk("err_done", comp_q.size(), 1);
    tick();
    chk("err_sticky", bus.ram_err, 1'b1);
    err_n = 0;
    comp_q.delete();
    run_until(1, 20);
    bus.dREN = 1'b0;
    tick();
    chk("err_sticky2", bus.ram_err, 1'b1);
    do_reset();
    chk("err_cleared", bus.ram_err, 1'b0);

    // abandon mid-BUSY, then reset mid-BUSY
    bus.dREN = 1'b1; bus.daddr = 32'h48; lat = 6;
    comp_q.delete();
    tick(); tick(); tick();
    bus.dREN = 1'b0;
    tick(); tick();
    chk("abort_nopulse", comp_q.size(), 0);
    bus.dREN = 1'b1;
    tick(); tick(); tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rstmid_ren", bus.ramREN, 1'b0);
    chk("rstmid_dwait", bus.dwait, 1'b1);
    bus.dREN = 1'b0;
    tick();
    chk("rstmid_nopulse", comp_q.size(), 0);

    // random traffic against the model
    rnd_ram = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      bus.iREN   = ($urandom_range(0, 9) < 6);
      bus.dREN   = ($urandom_range(0, 9) < 6);
      bus.dWEN   = ($urandom_range(0, 9) < 2);
      bus.iaddr  = $urandom;
      bus.daddr  = $urandom;
      bus.dstore = $urandom;
      RST        = ($urandom_range(0, 199) == 0);
      tick();
    end
    RST = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
